// File: rtl/bus_arbiter_if.sv
// Shared-memory arbiter bus bundle: instruction-fetch port, data port, flush and memory port.
// The slave modport is the arbiter's view; the master modport is the CPU/memory environment's view.
interface bus_arbiter_if #(
  parameter int unsigned DW = 32
);
  logic          i_req;
  logic [DW-1:0] i_addr;
  logic          i_addr_ok;
  logic          i_data_ok;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_wr;
  logic [1:0]    d_size;
  logic [DW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_addr_ok;
  logic          d_data_ok;
  logic [DW-1:0] d_rdata;

  logic          flush;

  logic          m_req;
  logic          m_wr;
  logic [1:0]    m_size;
  logic [DW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_addr_ok;
  logic          m_data_ok;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_size, d_addr, d_wdata, flush,
           m_addr_ok, m_data_ok, m_rdata,
    output i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
           m_req, m_wr, m_size, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_size, d_addr, d_wdata, flush,
           m_addr_ok, m_data_ok, m_rdata,
    input  i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
           m_req, m_wr, m_size, m_addr, m_wdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master (fetch/data) arbiter onto a single memory port, one transaction outstanding.
// Optional macro BUS_ARBITER_RR_EN replaces fixed data-first priority with round-robin.
module bus_arbiter #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;

  state_t        state_q, state_d;
  logic          gnt_d_q, gnt_d_d;       // 1 = data port owns the current transaction
  logic          discard_q, discard_d;
  logic [DW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          m_wr_q, m_wr_d;
  logic [1:0]    m_size_q, m_size_d;

  logic          prio_d_c;
  logic          sel_d_c;
  logic          i_addr_ok_c, d_addr_ok_c, i_data_ok_c, d_data_ok_c;

`ifdef BUS_ARBITER_RR_EN
  logic          last_d_q, last_d_d;     // 1 = data port was granted last
  assign prio_d_c = ~last_d_q;
`else
  assign prio_d_c = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_d_q   <= 1'b0;
      discard_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wr_q    <= 1'b0;
      m_size_q  <= 2'd0;
`ifdef BUS_ARBITER_RR_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_d_q   <= gnt_d_d;
      discard_q <= discard_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wr_q    <= m_wr_d;
      m_size_q  <= m_size_d;
`ifdef BUS_ARBITER_RR_EN
      last_d_q  <= last_d_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d_d     = gnt_d_q;
    discard_d   = discard_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_wr_d      = m_wr_q;
    m_size_d    = m_size_q;
    i_addr_ok_c = 1'b0;
    d_addr_ok_c = 1'b0;
    i_data_ok_c = 1'b0;
    d_data_ok_c = 1'b0;
    sel_d_c     = bus.d_req & (~bus.i_req | prio_d_c);
`ifdef BUS_ARBITER_RR_EN
    last_d_d    = last_d_q;
`endif

    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (bus.d_req | bus.i_req) begin
          state_d = ADDR;
          gnt_d_d = sel_d_c;
`ifdef BUS_ARBITER_RR_EN
          last_d_d = sel_d_c;
`endif
          if (sel_d_c) begin
            d_addr_ok_c = 1'b1;
            m_addr_d    = bus.d_addr;
            m_wdata_d   = bus.d_wdata;
            m_wr_d      = bus.d_wr;
            m_size_d    = bus.d_size;
          end else begin
            i_addr_ok_c = 1'b1;
            m_addr_d    = bus.i_addr;
            m_wdata_d   = '0;
            m_wr_d      = 1'b0;
            m_size_d    = 2'd2;
            discard_d   = bus.flush;
          end
        end
      end
      ADDR: begin
        if (bus.flush & ~gnt_d_q) discard_d = 1'b1;
        if (bus.m_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (bus.flush & ~gnt_d_q) discard_d = 1'b1;
        if (bus.m_data_ok) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          // A flush arriving with the response still drops it.
          if (gnt_d_q) d_data_ok_c = 1'b1;
          else         i_data_ok_c = ~(discard_q | bus.flush);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshakes are gated by reset so every output reads 0 while it is held.
  assign bus.i_addr_ok = i_addr_ok_c & ~reset;
  assign bus.d_addr_ok = d_addr_ok_c & ~reset;
  assign bus.i_data_ok = i_data_ok_c & ~reset;
  assign bus.d_data_ok = d_data_ok_c & ~reset;
  assign bus.i_rdata   = (i_data_ok_c & ~reset) ? bus.m_rdata : '0;
  assign bus.d_rdata   = (d_data_ok_c & ~reset) ? bus.m_rdata : '0;

  assign bus.m_req   = (state_q == ADDR) & ~reset;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_wr    = m_wr_q;
  assign bus.m_size  = m_size_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (default build: fixed data-first priority).
module tb_bus_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  bus_arbiter_if #(.DW(32)) bus ();

  bus_arbiter #(.DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.i_req = 1'b0;  bus.i_addr = '0;
    bus.d_req = 1'b0;  bus.d_wr = 1'b0; bus.d_size = 2'd0;
    bus.d_addr = '0;   bus.d_wdata = '0;
    bus.flush = 1'b0;
    bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0; bus.m_rdata = '0;

    #12;
    chk("rst_m_req",     32'(bus.m_req), 32'd0);
    chk("rst_i_addr_ok", 32'(bus.i_addr_ok), 32'd0);
    chk("rst_d_addr_ok", 32'(bus.d_addr_ok), 32'd0);
    chk("rst_m_addr",    bus.m_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fetch read
    tick();
    bus.i_req = 1'b1; bus.i_addr = 32'hBFC0_0000;
    #1;
    chk("f_i_addr_ok", 32'(bus.i_addr_ok), 32'd1);
    chk("f_d_addr_ok", 32'(bus.d_addr_ok), 32'd0);
    chk("f_m_req_c0",  32'(bus.m_req), 32'd0);
    tick();
    bus.i_req = 1'b0; bus.m_addr_ok = 1'b1;
    #1;
    chk("f_m_req_c1",  32'(bus.m_req), 32'd1);
    chk("f_m_addr",    bus.m_addr, 32'hBFC0_0000);
    chk("f_m_wr",      32'(bus.m_wr), 32'd0);
    chk("f_m_size",    32'(bus.m_size), 32'd2);
    chk("f_no_aok_c1", 32'(bus.i_addr_ok), 32'd0);
    tick();
    bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1; bus.m_rdata = 32'h3C08_0001;
    #1;
    chk("f_i_data_ok", 32'(bus.i_data_ok), 32'd1);
    chk("f_i_rdata",   bus.i_rdata, 32'h3C08_0001);
    chk("f_d_data_ok", 32'(bus.d_data_ok), 32'd0);
    chk("f_d_rdata",   bus.d_rdata, 32'd0);
    chk("f_m_req_c2",  32'(bus.m_req), 32'd0);

    // Simultaneous requests: data wins, fetch accepted in cycle 3
    tick();
    bus.m_data_ok = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_size = 2'd2; bus.d_addr = 32'h200;
    #1;
    chk("s_i_rdata_idle", bus.i_rdata, 32'd0);
    chk("s_d_addr_ok", 32'(bus.d_addr_ok), 32'd1);
    chk("s_i_addr_ok", 32'(bus.i_addr_ok), 32'd0);
    tick();
    bus.d_req = 1'b0; bus.m_addr_ok = 1'b1;
    #1;
    chk("s_m_addr_d",   bus.m_addr, 32'h200);
    chk("s_i_held_c1",  32'(bus.i_addr_ok), 32'd0);
    tick();
    bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1; bus.m_rdata = 32'h5555_AAAA;
    #1;
    chk("s_d_data_ok",  32'(bus.d_data_ok), 32'd1);
    chk("s_d_rdata",    bus.d_rdata, 32'h5555_AAAA);
    chk("s_i_data_ok",  32'(bus.i_data_ok), 32'd0);
    chk("s_i_held_c2",  32'(bus.i_addr_ok), 32'd0);
    tick();
    bus.m_data_ok = 1'b0;
    #1;
    chk("s_i_aok_c3",   32'(bus.i_addr_ok), 32'd1);
    tick();
    bus.i_req = 1'b0; bus.m_addr_ok = 1'b1;
    #1;
    chk("s_m_addr_i",   bus.m_addr, 32'h100);
    chk("s_m_wr_i",     32'(bus.m_wr), 32'd0);
    tick();
    bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1; bus.m_rdata = 32'h0000_0066;
    #1;
    chk("s_i_data_ok2", 32'(bus.i_data_ok), 32'd1);
    chk("s_i_rdata2",   bus.i_rdata, 32'h0000_0066);

    // Byte store stalled for 3 cycles without m_addr_ok
    tick();
    bus.m_data_ok = 1'b0;
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_size = 2'd0;
    bus.d_addr = 32'h8000_0003; bus.d_wdata = 32'h0000_00AB;
    #1;
    chk("w_d_addr_ok", 32'(bus.d_addr_ok), 32'd1);
    tick();
    bus.d_req = 1'b0; bus.d_wdata = 32'hFFFF_FFFF; bus.d_addr = 32'h0; bus.d_wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("w_stall_m_req",   32'(bus.m_req), 32'd1);
      chk("w_stall_m_wr",    32'(bus.m_wr), 32'd1);
      chk("w_stall_m_size",  32'(bus.m_size), 32'd0);
      chk("w_stall_m_wdata", bus.m_wdata, 32'h0000_00AB);
      chk("w_stall_m_addr",  bus.m_addr, 32'h8000_0003);
      tick();
    end
    bus.m_addr_ok = 1'b1;
    #1;
    chk("w_m_req_aok", 32'(bus.m_req), 32'd1);
    tick();
    bus.m_addr_ok = 1'b0;
    #1;
    chk("w_wait_dok",   32'(bus.d_data_ok), 32'd0);
    chk("w_wait_wdata", bus.m_wdata, 32'h0000_00AB);
    chk("w_wait_m_req", 32'(bus.m_req), 32'd0);
    tick();
    bus.m_data_ok = 1'b1; bus.m_rdata = 32'h0;
    #1;
    chk("w_d_data_ok",  32'(bus.d_data_ok), 32'd1);
    tick();
    bus.m_data_ok = 1'b0;
    #1;
    chk("w_dok_once",   32'(bus.d_data_ok), 32'd0);

    // Flush during the WAIT of a fetch suppresses its response
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    #1;
    chk("fl_i_addr_ok", 32'(bus.i_addr_ok), 32'd1);
    tick();
    bus.i_req = 1'b0; bus.m_addr_ok = 1'b1;
    tick();
    bus.m_addr_ok = 1'b0; bus.flush = 1'b1;
    #1;
    chk("fl_wait_iok",  32'(bus.i_data_ok), 32'd0);
    tick();
    bus.flush = 1'b0; bus.m_data_ok = 1'b1; bus.m_rdata = 32'hDEAD_BEEF;
    #1;
    chk("fl_i_data_ok", 32'(bus.i_data_ok), 32'd0);
    chk("fl_i_rdata",   bus.i_rdata, 32'd0);
    tick();
    bus.m_data_ok = 1'b0;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_size = 2'd2; bus.d_addr = 32'h300;
    #1;
    chk("fl_next_aok",  32'(bus.d_addr_ok), 32'd1);

    // Reset in the WAIT of a data load
    tick();
    bus.d_req = 1'b0; bus.m_addr_ok = 1'b1;
    tick();
    bus.m_addr_ok = 1'b0;
    #1;
    chk("r_pre_m_addr", bus.m_addr, 32'h300);
    reset = 1'b1;
    #1;
    chk("r_m_req",      32'(bus.m_req), 32'd0);
    chk("r_m_addr",     bus.m_addr, 32'd0);
    chk("r_d_data_ok",  32'(bus.d_data_ok), 32'd0);
    chk("r_d_addr_ok",  32'(bus.d_addr_ok), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    bus.m_data_ok = 1'b1; bus.m_rdata = 32'h1234_5678;
    #1;
    chk("r_late_dok",   32'(bus.d_data_ok), 32'd0);
    chk("r_late_drd",   bus.d_rdata, 32'd0);
    chk("r_late_m_req", 32'(bus.m_req), 32'd0);
    tick();
    bus.m_data_ok = 1'b0; bus.i_req = 1'b1; bus.i_addr = 32'h80;
    #1;
    chk("r_idle_aok",   32'(bus.i_addr_ok), 32'd1);
    tick();
    bus.i_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32: width of address and data buses.
REQ-002 SHALL have ports clk, in, 1: sole clock (rising edge).
REQ-003 SHALL have ports reset, in, 1: asynchronous, active-high reset.
REQ-004 SHALL have i_req, in, 1: instruction fetch read request, held until i_addr_ok.
REQ-005 SHALL have i_addr, in, DW: fetch address.
REQ-006 SHALL have i_addr_ok, out, 1: fetch request accepted.
REQ-007 SHALL have i_data_ok, out, 1: fetch data valid.
REQ-008 SHALL have i_rdata, out, DW: fetch data.
REQ-009 SHALL have d_req, in, 1: data request, held until d_addr_ok.
REQ-010 SHALL have d_wr, in, 1: 1 = store, 0 = load.
REQ-011 SHALL have d_size, in, 2: 0 = byte, 1 = half, 2 = word.
REQ-012 SHALL have d_addr and d_wdata, in, DW each: data address and store data.
REQ-013 SHALL have d_addr_ok, d_data_ok, out, 1 each; d_rdata, out, DW: data handshake and load data.
REQ-014 SHALL have flush, in, 1: pipeline flush; drop any pending fetch response.
REQ-015 SHALL have m_req, m_wr, out, 1 each; m_size, out, 2; m_addr, m_wdata, out, DW each: shared memory port.
REQ-016 SHALL have m_addr_ok, m_data_ok, in, 1 each; m_rdata, in, DW: memory handshake and read data.

Function
REQ-017 SHALL implement states IDLE, ADDR, WAIT, with exactly one memory transaction outstanding.
REQ-018 IDLE: if any request is present, grant it, register its fields into m_* regs, pulse the granted x_addr_ok for that cycle, then go to ADDR.
REQ-019 Default grant priority SHALL be: d_req over i_req.
REQ-020 ADDR: assert m_req with the registered fields; on m_addr_ok go to WAIT; m_data_ok is ignored in ADDR.
REQ-021 WAIT: on m_data_ok, drive the granted x_data_ok combinationally with x_rdata = m_rdata, then go to IDLE.
REQ-022 Minimum latency SHALL be 3 cycles: accept in cycle 0, m_req/m_addr_ok in cycle 1, m_data_ok/x_data_ok in cycle 2; the next accept is in cycle 3.
REQ-023 Fields m_addr, m_wr, m_size and m_wdata SHALL stay stable from ADDR entry through WAIT exit.
REQ-024 Fetch grants SHALL force m_wr = 0 and m_size = 2.
REQ-025 Discard flag: set by flush while the fetch grant is in ADDR or WAIT, or in the fetch accept cycle.
REQ-026 While the discard flag is set, i_data_ok SHALL be suppressed; the transaction still completes on the bus; the flag clears on return to IDLE.
REQ-027 Flush SHALL not affect data grants or d_* responses.
REQ-028 i_rdata and d_rdata SHALL be forced to 0 when their data_ok is low.
REQ-029 x_addr_ok SHALL never be asserted outside IDLE, and i_addr_ok and d_addr_ok SHALL never be asserted in the same cycle.

Reset
REQ-030 On reset assertion, the block SHALL enter IDLE asynchronously.
REQ-031 Reset SHALL drive every output to 0, clear the m_* registers, the discard flag and the round-robin pointer, and abandon any in-flight transaction without a response.

Configuration
REQ-032 With macro BUS_ARBITER_RR_EN defined, a 1-bit last-grant pointer SHALL be kept: when both requesters are active in IDLE, the one not granted last wins; on a single request, that requester wins and the pointer updates.
REQ-033 Without BUS_ARBITER_RR_EN, fixed data-first priority (REQ-019) SHALL apply and no pointer register SHALL exist.

Verification
REQ-034 Fetch read: i_req, i_addr = 0xBFC00000; m_addr_ok in cycle 1; m_data_ok, m_rdata = 0x3C080001 in cycle 2 -> i_addr_ok in cycle 0, m_addr = 0xBFC00000, m_wr = 0, m_size = 2; i_data_ok with i_rdata = 0x3C080001 in cycle 2.
REQ-035 Simultaneous requests: i_req (0x100) and d_req (load, 0x200) held, no RR -> d served first, m_addr = 0x200; i accepted in cycle 3, m_addr = 0x100. With RR and last grant = d, i is served first.
REQ-036 Store: d_wr = 1, d_size = 0, d_addr = 0x80000003, d_wdata = 0xAB -> m_wr = 1, m_size = 0, m_wdata = 0xAB held through 3 stall cycles without m_addr_ok; d_data_ok pulses once.
REQ-037 Flush: flush in the WAIT cycle of a fetch -> m_data_ok arrives, i_data_ok stays 0, i_rdata = 0; the next request is accepted the following cycle.
REQ-038 Reset mid-operation: reset in WAIT of a data load -> all outputs 0 asynchronously, state IDLE; a late m_data_ok after release produces no d_data_ok.
